// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared mode encodings and FSM state type for the CPU clock-enable controller.
package cpu_clk_ctrl_pkg;

  localparam logic [1:0] MODE_HALT    = 2'b00;
  localparam logic [1:0] MODE_RUN     = 2'b01;
  localparam logic [1:0] MODE_STEP    = 2'b10;
  localparam logic [1:0] MODE_RUN_ALT = 2'b11;

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_BP   = 2'd3
  } state_t;

  function automatic logic mode_is_run(input logic [1:0] m);
    return (m == MODE_RUN) || (m == MODE_RUN_ALT);
  endfunction

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Step button conditioning: 2-flop synchroniser, stable-level debounce, one-cycle rise pulse.
module btn_debounce
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic step_req
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      level    <= 1'b0;
      cnt      <= '0;
      step_req <= 1'b0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      step_req <= 1'b0;
      // Any return to the accepted level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level    <= sync2;
        cnt      <= '0;
        step_req <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: HALT / divided RUN / debounced STEP, one-cycle cpu_ce, no gated clocks.
// Optional PC breakpoint in RUN is compiled in with macro BREAKPOINT_EN.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DIV_W      = 8,
  parameter int DEB_CYCLES = 250000,
  parameter int PC_W       = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_val,
  input  logic             btn,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  output logic             cpu_ce,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] ce_cnt
);

  state_t           state;
  state_t           state_n;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_lat;
  logic             step_req;
  logic             step_ce;
  logic             set_step;
  logic             run_ce;
  logic             bp_hit_n;
  logic             bp_match;
  logic             m_run;
  logic             m_step;
  logic             m_halt;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .step_req(step_req)
  );

`ifdef BREAKPOINT_EN
  assign bp_match = bp_valid && (pc == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_valid};
  assign bp_match  = 1'b0;
`endif

  assign m_run  = mode_is_run(mode);
  assign m_step = (mode == MODE_STEP);
  assign m_halt = (mode == MODE_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HALT;
    else     state <= state_n;
  end

  // Priority inside every state: mode change, then step_req, then divider.
  always_comb begin
    state_n  = state;
    run_ce   = 1'b0;
    set_step = 1'b0;
    bp_hit_n = bp_hit;
    case (state)
      S_HALT: begin
        if (m_run)       state_n = S_RUN;
        else if (m_step) state_n = S_STEP;
      end
      S_RUN: begin
        if (m_halt) begin
          state_n = S_HALT;
        end else if (m_step) begin
          state_n = S_STEP;
        end else if (bp_match && !step_ce) begin
          state_n  = S_BP;
          bp_hit_n = 1'b1;
        end else if (cnt == div_lat) begin
          run_ce = 1'b1;
        end
      end
      S_STEP: begin
        if (m_halt)        state_n = S_HALT;
        else if (m_run)    state_n = S_RUN;
        else if (step_req) set_step = 1'b1;
      end
      S_BP: begin
        if (m_halt) begin
          state_n  = S_HALT;
          bp_hit_n = 1'b0;
        end else if (step_req) begin
          state_n  = S_RUN;
          set_step = 1'b1;
          bp_hit_n = 1'b0;
        end
      end
      default: state_n = S_HALT;
    endcase
  end

  // step_ce also masks the breakpoint compare on the first RUN cycle after a BP step.
  assign cpu_ce = run_ce | step_ce;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      div_lat <= '0;
    end else if (state_n == S_RUN && state != S_RUN) begin
      cnt     <= '0;
      div_lat <= div_val;
    end else if (state_n == S_RUN) begin
      if (cnt == div_lat) begin
        cnt     <= '0;
        div_lat <= div_val;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_ce <= 1'b0;
      halted  <= 1'b1;
      bp_hit  <= 1'b0;
      ce_cnt  <= '0;
    end else begin
      step_ce <= set_step;
      halted  <= (state_n != S_RUN);
      bp_hit  <= bp_hit_n;
      if (cpu_ce) ce_cnt <= ce_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed self-checking bench for cpu_clk_ctrl (DEB_CYCLES=4).
module tb_cpu_clk_ctrl;
  import cpu_clk_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [7:0]  div_val;
  logic        btn;
  logic [15:0] pc;
  logic [15:0] bp_addr;
  logic        bp_valid;
  logic        cpu_ce;
  logic        halted;
  logic        bp_hit;
  logic [31:0] ce_cnt;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   last_pulse = 0;
  int   gaps[$];
  logic ce_seen = 1'b0;
  logic pc_clr;

  int          p0;
  int          g0;
  logic [31:0] c0;

  cpu_clk_ctrl #(
    .DIV_W(8), .DEB_CYCLES(4), .PC_W(16), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .div_val(div_val), .btn(btn),
    .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .cpu_ce(cpu_ce), .halted(halted), .bp_hit(bp_hit), .ce_cnt(ce_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ce_seen <= cpu_ce;
    if (cpu_ce === 1'b1) begin
      gaps.push_back(cyc - last_pulse);
      last_pulse = cyc;
      pulses++;
    end
  end

  // Toy CPU: the program counter advances on the edge that consumes a ce.
  always @(posedge clk) begin
    if (pc_clr)       pc <= 16'h0000;
    else if (ce_seen) pc <= pc + 16'h0001;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = MODE_HALT; div_val = 8'd0; btn = 1'b0;
    bp_addr = 16'h0010; bp_valid = 1'b0; pc_clr = 1'b1;
    step_clk(3);
    check("rst_cpu_ce", cpu_ce, 1'b0);
    check("rst_halted", halted, 1'b1);
    check("rst_bp_hit", bp_hit, 1'b0);
    check("rst_ce_cnt", ce_cnt, 32'd0);
    rst = 1'b0; pc_clr = 1'b0;
    step_clk(2);

    // RUN div=3 for 40 cycles after the HALT->RUN transition
    p0 = pulses; mode = MODE_RUN; div_val = 8'd3;
    step_clk(41);
    check("run3_pulses", pulses - p0, 10);
    check("run3_ce_cnt", ce_cnt, 32'd10);
    check("run3_halted", halted, 1'b0);
    check("run3_gap", gaps[gaps.size()-1], 4);
    mode = MODE_HALT;
    step_clk(3);

    // div 0 -> 7 mid-run: the pending period ends at the old ratio
    mode = MODE_RUN; div_val = 8'd0;
    step_clk(6);
    div_val = 8'd7; g0 = gaps.size(); p0 = pulses;
    step_clk(30);
    check("div_chg_pulses", pulses - p0, 4);
    check("div_chg_gap0", gaps[g0], 1);
    check("div_chg_gap1", gaps[g0+1], 8);
    check("div_chg_gap3", gaps[g0+3], 8);
    mode = MODE_HALT;
    step_clk(3);

    // RUN->HALT exactly on the terminal divider count
    mode = MODE_RUN; div_val = 8'd3; p0 = pulses;
    step_clk(4);
    check("halt_edge_pre_halted", halted, 1'b0);
    mode = MODE_HALT;
    #1;
    check("halt_edge_ce", cpu_ce, 1'b0);
    step_clk(1);
    check("halt_edge_halted", halted, 1'b1);
    check("halt_edge_pulses", pulses - p0, 0);
    step_clk(2);

    // STEP with a bouncing press, then a clean press
    mode = MODE_STEP;
    step_clk(2);
    p0 = pulses; c0 = ce_cnt;
    btn = 1'b1; step_clk(1);
    btn = 1'b0; step_clk(1);
    btn = 1'b1; step_clk(20);
    btn = 1'b0; step_clk(10);
    check("step_bounce_pulses", pulses - p0, 1);
    check("step_halted", halted, 1'b1);
    btn = 1'b1; step_clk(10);
    btn = 1'b0; step_clk(10);
    check("step_second_pulses", pulses - p0, 2);
    check("step_ce_cnt", ce_cnt - c0, 32'd2);
    mode = MODE_HALT;
    step_clk(3);

    // Breakpoint at 0x0010 while running at div 0
    pc_clr = 1'b1; step_clk(1); pc_clr = 1'b0;
    bp_valid = 1'b1; bp_addr = 16'h0010; mode = MODE_RUN; div_val = 8'd0; p0 = pulses;
    step_clk(30);
`ifdef BREAKPOINT_EN
    check("bp_pc", pc, 16'h0010);
    check("bp_hit", bp_hit, 1'b1);
    check("bp_halted", halted, 1'b1);
    check("bp_pulses", pulses - p0, 16);
    btn = 1'b1; step_clk(10);
    btn = 1'b0; step_clk(10);
    check("bp_resume_hit", bp_hit, 1'b0);
    check("bp_resume_halted", halted, 1'b0);
    check("bp_resume_pc_past", pc > 16'h0011, 1'b1);
`else
    check("nobp_pc", pc, 16'd29);
    check("nobp_hit", bp_hit, 1'b0);
    check("nobp_halted", halted, 1'b0);
    check("nobp_pulses", pulses - p0, 29);
`endif
    mode = MODE_HALT; bp_valid = 1'b0;
    step_clk(3);
    check("bp_end_halted", halted, 1'b1);

    // Async reset in the middle of a div=5 period
    mode = MODE_RUN; div_val = 8'd5;
    step_clk(4);
    rst = 1'b1;
    #1;
    check("arst_cpu_ce", cpu_ce, 1'b0);
    check("arst_halted", halted, 1'b1);
    check("arst_ce_cnt", ce_cnt, 32'd0);
    check("arst_bp_hit", bp_hit, 1'b0);
    mode = MODE_HALT;
    step_clk(2);
    rst = 1'b0; p0 = pulses;
    step_clk(10);
    check("arst_idle_pulses", pulses - p0, 0);
    check("arst_idle_halted", halted, 1'b1);
    mode = MODE_RUN;
    step_clk(7);
    check("arst_rerun_pulses", pulses - p0, 1);
    check("arst_rerun_ce_cnt", ce_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
